reg_bus_xfer_ctrl: RTL and testbench
====================================

Name: reg_bus_xfer_ctrl

Overview:
Bus master that sequences transfers over the shared 4-bit register bus. The bus is built from reg4-style registers, each with a load enable (inen) and an output enable (oen).
- Accepts one command at a time over a valid/ready handshake.
- Drives one-hot oen/inen strobes to a bank of registers to move data between them, load an immediate, or read one back.
- Sits between the control sequencer and the register bank.
- Guarantees that at most one bus driver is enabled in any cycle.

Parameters:
NREG, 4, number of registers on the bus (2..8); strobe vectors are NREG wide.
WIDTH, 4, bus/data width.
AW, 2, register index width; must satisfy 2**AW >= NREG.

Ports:
clk  in  1  rising-edge clock.
clr_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command (high only in IDLE).
cmd_op  in  2  00 MOVE, 01 LOADI, 10 READ, 11 reserved.
cmd_src  in  AW  source register index (MOVE, READ).
cmd_dst  in  AW  destination register index (MOVE, LOADI).
cmd_imm  in  WIDTH  immediate value (LOADI).
reg_oen  out  NREG  one-hot register output enables.
reg_inen  out  NREG  one-hot register load enables.
bus_drive  out  1  controller drives bus_out onto the bus.
bus_out  out  WIDTH  immediate value driven when bus_drive=1.
bus_in  in  WIDTH  resolved bus value.
rd_data  out  WIDTH  last value captured by READ.
done  out  1  one-cycle pulse when a command retires.
err  out  1  valid with done; 1 for a reserved op or an index >= NREG.

Behaviour:
Reset (clr_n low, asynchronous):
- State goes to IDLE.
- reg_oen=0, reg_inen=0, bus_drive=0, bus_out=0, rd_data=0, done=0, err=0.
- cmd_ready=0 while clr_n is low; it rises in the first cycle after release.

Handshake:
- A command is accepted on a rising edge where cmd_valid && cmd_ready.
- All cmd_* fields are registered at acceptance. Later changes on the inputs have no effect.

FSM states: IDLE, DRIVE, LATCH, DONE. Outputs are registered per state.
- IDLE: cmd_ready=1, all strobes 0. On accept, go to DRIVE.
- DRIVE (settle cycle):
  - MOVE/READ: reg_oen[src]=1.
  - LOADI: bus_drive=1, bus_out=imm.
  - No inen is asserted. Go to LATCH.
- LATCH: keep the DRIVE enables, plus:
  - MOVE/LOADI: reg_inen[dst]=1 for exactly this cycle.
  - READ: rd_data <= bus_in at the end of LATCH.
  - Go to DONE.
- DONE:
  - All strobes 0, bus_drive=0.
  - done=1 for one cycle, err as defined below.
  - Go to IDLE.
  - bus_out holds its value; it is don't-care while bus_drive=0.

Latency and throughput:
- Accept at edge T, done high in cycle T+3.
- Next accept no earlier than edge T+4, so 4 cycles per command.

Invariants:
- popcount(reg_oen) + bus_drive <= 1 in every cycle.
- popcount(reg_inen) <= 1 in every cycle.
- inen is asserted only in LATCH.

Boundary cases:
- MOVE with src==dst: runs the full sequence, asserts oen only, no inen, done=1, err=0.
- Reserved op or index >= NREG: no strobes in DRIVE or LATCH, rd_data unchanged, done=1 with err=1.
- cmd_valid held high across done: the next command is accepted in the IDLE cycle after DONE.
- Reset mid-command: all strobes drop immediately (asynchronous), the destination is not loaded, no done pulse.

Decomposition:
- Shared package reg_bus_pkg holds:
  - Op encodings OP_MOVE, OP_LOADI, OP_READ, OP_RSVD.
  - State encodings ST_IDLE, ST_DRIVE, ST_LATCH, ST_DONE.
  - Default WIDTH and NREG.
- One natural sub-module, onehot_dec (AW-to-NREG decoder with an enable input and an out-of-range flag). It is instantiated twice, for src and for dst.
- The FSM and datapath stay in the top module.

Test Plan:
Bench setup: a model bank of four reg4-style registers, each with async clear, on a resolved bus.
1. Reset: hold clr_n=0 for 2 cycles mid-run -> all outputs 0, cmd_ready=0; first cycle after release cmd_ready=1.
2. LOADI dst=2 imm=4'b0101 -> bus_drive=1 with bus_out=0101 in DRIVE and LATCH; reg_inen=4'b0100 in LATCH only; reg2=0101; done in cycle T+3, err=0.
3. MOVE src=2 dst=0 after LOADI 4'hD into reg2 -> reg_oen=4'b0100 for 2 cycles, reg_inen=4'b0001 for 1 cycle; reg0=4'hD; reg2 unchanged.
4. READ src=0 -> rd_data=4'hD at done. Then READ of a register never loaded -> rd_data=0.
5. Back-to-back commands with cmd_valid held high: LOADI r1=4'hA then MOVE r1->r3 -> second accept exactly 4 cycles after the first, r3=4'hA. A checker asserts the single-driver and single-inen invariants in every cycle.
6. Error and mid-command reset:
   - op=11 -> done=1, err=1, no strobes.
   - MOVE src=dst=1 -> no inen, err=0.
   - Reset asserted during LATCH of LOADI r3=4'h7 -> strobes drop asynchronously, no done, r3 keeps its prior value.

Source files
------------

// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_pkg
// Brief   : Op/state encodings and defaults shared by the register-bus master.
// Revision: 1.0
// ============================================================================
package reg_bus_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREG  = 4;

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_LOADI = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DRIVE = 2'b01;
    localparam logic [1:0] ST_LATCH = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    function automatic logic uses_src(input logic [1:0] op);
        return (op == OP_MOVE) || (op == OP_READ);
    endfunction

    function automatic logic uses_dst(input logic [1:0] op);
        return (op == OP_MOVE) || (op == OP_LOADI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bus_xfer_ctrl_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module  : onehot_dec
// Brief   : Index-to-one-hot decoder with enable and out-of-range flag.
// Revision: 1.0
// ============================================================================
module onehot_dec #(
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic            i_en,
    input  logic [AW-1:0]   i_idx,
    output logic [NREG-1:0] o_onehot,
    output logic            o_oor
);

    assign o_oor = ({{(32-AW){1'b0}}, i_idx} >= NREG);

    // An index that matches bit i is in range by construction.
    for (genvar i = 0; i < NREG; i++) begin : g_bit
        assign o_onehot[i] = i_en && (i_idx == AW'(i));
    end

endmodule
`default_nettype wire

// File: rtl/reg_bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_xfer_ctrl
// Brief   : Four-phase bus master driving one-hot oen/inen register strobes.
// Revision: 1.0
// ============================================================================
module reg_bus_xfer_ctrl
    import reg_bus_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_src,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [NREG-1:0]  reg_oen,
    output logic [NREG-1:0]  reg_inen,
    output logic             bus_drive,
    output logic [WIDTH-1:0] bus_out,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] rd_data,
    output logic             done,
    output logic             err
);

    logic [1:0]       r_state;
    logic             r_ready;
    logic [1:0]       r_op;
    logic [AW-1:0]    r_src;
    logic [AW-1:0]    r_dst;
    logic [NREG-1:0]  r_oen;
    logic [NREG-1:0]  r_inen;
    logic             r_drive;
    logic [WIDTH-1:0] r_bus_out;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic [1:0]       w_op;
    logic [AW-1:0]    w_src;
    logic [AW-1:0]    w_dst;
    logic             w_src_oor;
    logic             w_dst_oor;
    logic             w_err;
    logic             w_src_en;
    logic             w_dst_en;
    logic [NREG-1:0]  w_src_oh;
    logic [NREG-1:0]  w_dst_oh;

    // The DRIVE strobes are registered on the accept edge, so decode straight
    // from the command inputs in that cycle and from the held copy afterwards.
    assign w_accept = cmd_valid && r_ready;
    assign w_op     = w_accept ? cmd_op  : r_op;
    assign w_src    = w_accept ? cmd_src : r_src;
    assign w_dst    = w_accept ? cmd_dst : r_dst;

    assign w_err = (w_op == OP_RSVD)
                 || (uses_src(w_op) && w_src_oor)
                 || (uses_dst(w_op) && w_dst_oor);

    assign w_src_en = uses_src(w_op) && !w_err;
    assign w_dst_en = uses_dst(w_op) && !w_err
                   && !((w_op == OP_MOVE) && (w_src == w_dst));

    onehot_dec #(.NREG(NREG), .AW(AW)) u_src_dec (
        .i_en     (w_src_en),
        .i_idx    (w_src),
        .o_onehot (w_src_oh),
        .o_oor    (w_src_oor)
    );

    onehot_dec #(.NREG(NREG), .AW(AW)) u_dst_dec (
        .i_en     (w_dst_en),
        .i_idx    (w_dst),
        .o_onehot (w_dst_oh),
        .o_oor    (w_dst_oor)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b0;
            r_op      <= OP_MOVE;
            r_src     <= '0;
            r_dst     <= '0;
            r_oen     <= '0;
            r_inen    <= '0;
            r_drive   <= 1'b0;
            r_bus_out <= '0;
            r_rd_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_ready) begin
                        r_ready <= 1'b1;
                    end else if (cmd_valid) begin
                        r_ready <= 1'b0;
                        r_op    <= cmd_op;
                        r_src   <= cmd_src;
                        r_dst   <= cmd_dst;
                        r_oen   <= w_src_oh;
                        r_drive <= (cmd_op == OP_LOADI) && !w_err;
                        if ((cmd_op == OP_LOADI) && !w_err) begin
                            r_bus_out <= cmd_imm;
                        end
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_inen  <= w_dst_oh;
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_oen   <= '0;
                    r_inen  <= '0;
                    r_drive <= 1'b0;
                    r_done  <= 1'b1;
                    r_err   <= w_err;
                    if ((r_op == OP_READ) && !w_err) begin
                        r_rd_data <= bus_in;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign reg_oen   = r_oen;
    assign reg_inen  = r_inen;
    assign bus_drive = r_drive;
    assign bus_out   = r_bus_out;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bus_xfer_ctrl
// Brief   : Scoreboard bench with a four-register model bank on a resolved bus.
// Revision: 1.0
// ============================================================================
module tb_reg_bus_xfer_ctrl;

    localparam logic [1:0] C_MOVE  = 2'b00;
    localparam logic [1:0] C_LOADI = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_RSVD  = 2'b11;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       bank_clr_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_src;
    logic [1:0] cmd_dst;
    logic [3:0] cmd_imm;
    logic [3:0] reg_oen;
    logic [3:0] reg_inen;
    logic       bus_drive;
    logic [3:0] bus_out;
    logic [3:0] bus;
    logic [3:0] rd_data;
    logic       done;
    logic       err;

    logic [3:0] bank [4];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int         acc;
        logic [3:0] oen;
        logic [3:0] inen;
        logic       drive;
        logic [3:0] bout;
        logic       err;
        logic [3:0] rd;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bus_xfer_ctrl #(.NREG(4), .WIDTH(4), .AW(2)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_imm   (cmd_imm),
        .reg_oen   (reg_oen),
        .reg_inen  (reg_inen),
        .bus_drive (bus_drive),
        .bus_out   (bus_out),
        .bus_in    (bus),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err)
    );

    always_comb begin
        bus = 4'h0;
        if (bus_drive) bus = bus | bus_out;
        for (int i = 0; i < 4; i++) begin
            if (reg_oen[i]) bus = bus | bank[i];
        end
    end

    always_ff @(posedge clk or negedge bank_clr_n) begin
        if (!bank_clr_n) begin
            for (int i = 0; i < 4; i++) bank[i] <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (reg_inen[i]) bank[i] <= bus;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    // Monitor: every cycle out of reset, compare against the head of the queue.
    always @(negedge clk) begin
        exp_t h;
        int   d;
        if (clr_n) begin
            chk("single_driver", 32'(($countones(reg_oen) + int'(bus_drive)) <= 1), 32'd1);
            chk("single_inen", 32'($countones(reg_inen) <= 1), 32'd1);
            if (q.size() == 0) begin
                chk("idle_quiet", 32'({reg_oen, reg_inen, bus_drive, done}), 32'd0);
            end else begin
                h = q[0];
                d = cyc - h.acc;
                if (d < 0) begin
                    chk("idle_quiet", 32'({reg_oen, reg_inen, bus_drive, done}), 32'd0);
                end else if (d <= 1) begin
                    chk("phase_oen", 32'(reg_oen), 32'(h.oen));
                    chk((d == 1) ? "latch_inen" : "drive_inen", 32'(reg_inen),
                        (d == 1) ? 32'(h.inen) : 32'd0);
                    chk("phase_bus_drive", 32'(bus_drive), 32'(h.drive));
                    if (h.drive) chk("phase_bus_out", 32'(bus_out), 32'(h.bout));
                    chk("early_done", 32'(done), 32'd0);
                end else begin
                    chk("done_pulse", 32'(done), 32'd1);
                    chk("done_err", 32'(err), 32'(h.err));
                    chk("done_rd_data", 32'(rd_data), 32'(h.rd));
                    chk("done_strobes", 32'({reg_oen, reg_inen, bus_drive}), 32'd0);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [3:0] imm, input bit keep,
                         input logic [3:0] e_oen, input logic [3:0] e_inen,
                         input logic e_drive, input logic [3:0] e_bout,
                         input logic e_err, input logic [3:0] e_rd, output int acc);
        exp_t e;
        int   n;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        acc     = cyc + 1;
        e.acc   = acc;
        e.oen   = e_oen;
        e.inen  = e_inen;
        e.drive = e_drive;
        e.bout  = e_bout;
        e.err   = e_err;
        e.rd    = e_rd;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        // Scramble the inputs: the command must already be held inside.
        cmd_imm = ~imm;
        cmd_src = ~src;
        cmd_dst = ~dst;
        cmd_op  = ~op;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("retire_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        summary();
        $finish;
    end

    initial begin
        int a1;
        int a2;
        clr_n      = 1'b0;
        bank_clr_n = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_src    = 2'b00;
        cmd_dst    = 2'b00;
        cmd_imm    = 4'h0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({reg_oen, reg_inen, bus_drive, bus_out, rd_data, done, err}), 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        bank_clr_n = 1'b1;
        clr_n      = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // LOADI r2 = 0101
        issue(C_LOADI, 2'd0, 2'd2, 4'b0101, 1'b0, 4'b0000, 4'b0100, 1'b1, 4'b0101, 1'b0, 4'h0, a1);
        wait_idle();
        chk("bank2_loadi", 32'(bank[2]), 32'h5);

        // LOADI r2 = D, then MOVE r2 -> r0
        issue(C_LOADI, 2'd0, 2'd2, 4'hD, 1'b0, 4'b0000, 4'b0100, 1'b1, 4'hD, 1'b0, 4'h0, a1);
        wait_idle();
        issue(C_MOVE, 2'd2, 2'd0, 4'h0, 1'b0, 4'b0100, 4'b0001, 1'b0, 4'h0, 1'b0, 4'h0, a1);
        wait_idle();
        chk("bank0_move", 32'(bank[0]), 32'hD);
        chk("bank2_kept", 32'(bank[2]), 32'hD);

        // READ r0, then READ the never-loaded r1
        issue(C_READ, 2'd0, 2'd0, 4'h0, 1'b0, 4'b0001, 4'b0000, 1'b0, 4'h0, 1'b0, 4'hD, a1);
        wait_idle();
        issue(C_READ, 2'd1, 2'd0, 4'h0, 1'b0, 4'b0010, 4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, a1);
        wait_idle();

        // Back-to-back with cmd_valid held: LOADI r1 = A, MOVE r1 -> r3
        issue(C_LOADI, 2'd0, 2'd1, 4'hA, 1'b1, 4'b0000, 4'b0010, 1'b1, 4'hA, 1'b0, 4'h0, a1);
        issue(C_MOVE, 2'd1, 2'd3, 4'h0, 1'b0, 4'b0010, 4'b1000, 1'b0, 4'h0, 1'b0, 4'h0, a2);
        chk("b2b_accept_spacing", 32'(a2 - a1), 32'd4);
        wait_idle();
        chk("bank3_b2b", 32'(bank[3]), 32'hA);
        chk("bank1_b2b", 32'(bank[1]), 32'hA);

        // READ r3 so the reserved op below has a non-zero rd_data to preserve
        issue(C_READ, 2'd3, 2'd0, 4'h0, 1'b0, 4'b1000, 4'b0000, 1'b0, 4'h0, 1'b0, 4'hA, a1);
        wait_idle();
        issue(C_RSVD, 2'd2, 2'd1, 4'hF, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'h0, 1'b1, 4'hA, a1);
        wait_idle();
        issue(C_MOVE, 2'd1, 2'd1, 4'h0, 1'b0, 4'b0010, 4'b0000, 1'b0, 4'h0, 1'b0, 4'hA, a1);
        wait_idle();
        chk("bank1_self_move", 32'(bank[1]), 32'hA);

        // Reset asserted during LATCH of LOADI r3 = 7
        issue(C_LOADI, 2'd0, 2'd3, 4'h7, 1'b0, 4'b0000, 4'b1000, 1'b1, 4'h7, 1'b0, 4'hA, a1);
        @(negedge clk);
        #1;
        chk("latch_inen_pre_reset", 32'(reg_inen), 32'b1000);
        clr_n = 1'b0;
        #1;
        q.delete();
        chk("async_strobe_drop", 32'({reg_oen, reg_inen, bus_drive, done, cmd_ready}), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("held_reset_outputs", 32'({reg_oen, reg_inen, bus_drive, bus_out, rd_data, done, err}), 32'd0);
            chk("held_reset_ready", 32'(cmd_ready), 32'd0);
        end
        clr_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", 32'(cmd_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("bank3_not_loaded", 32'(bank[3]), 32'hA);

        summary();
        $finish;
    end

endmodule
`default_nettype wire
